// File: rtl/cpu_pkg.sv
// Shared opcode/state definitions and width defaults for the control unit.
// The HALT state exists only when ILLEGAL_TRAP_EN is defined.
package cpu_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int OP_W_DEF   = 3;

  typedef enum logic [2:0] {
    OP_LDX  = 3'b000,
    OP_LDY  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_CLR  = 3'b100,
    OP_DISP = 3'b101
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WRITE  = 3'd3
`ifdef ILLEGAL_TRAP_EN
    , ST_HALT = 3'd4
`endif
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational add/subtract; carry_o is carry-out for ADD and borrow (a<b) for SUB.
module alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              sub_i,
  output logic [DATA_W-1:0] res_o,
  output logic              carry_o
);

  logic [DATA_W:0] sum;

  // Zero-extended subtraction leaves the borrow in the top bit.
  always_comb begin
    if (sub_i) sum = {1'b0, a_i} - {1'b0, b_i};
    else       sum = {1'b0, a_i} + {1'b0, b_i};
  end

  assign res_o   = sum[DATA_W-1:0];
  assign carry_o = sum[DATA_W];

endmodule

// File: rtl/control_unit.sv
// Four-cycle IDLE/DECODE/EXEC/WRITE instruction sequencer with X/Y/Z registers.
// Optional macro ILLEGAL_TRAP_EN: opcodes 110/111 raise a sticky illegal flag and halt.
module control_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              flag_c,
  output logic              done,
  output logic              illegal
);

  state_e state_q, state_d;

  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] opnd_q;
  logic [DATA_W-1:0] x_q, y_q, z_q, dout_q;
  logic              flag_c_q;
  logic [DATA_W-1:0] res_q;
  logic              res_c_q;

  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              accept;

  logic is_ldx, is_ldy, is_add, is_sub, is_clr, is_disp;

  assign is_ldx  = (op_q == OP_W'(OP_LDX));
  assign is_ldy  = (op_q == OP_W'(OP_LDY));
  assign is_add  = (op_q == OP_W'(OP_ADD));
  assign is_sub  = (op_q == OP_W'(OP_SUB));
  assign is_clr  = (op_q == OP_W'(OP_CLR));
  assign is_disp = (op_q == OP_W'(OP_DISP));

`ifdef ILLEGAL_TRAP_EN
  logic is_illegal;
  assign is_illegal = !(is_ldx || is_ldy || is_add || is_sub || is_clr || is_disp);
`endif

  assign accept = instr_valid && instr_ready;

  alu #(.DATA_W(DATA_W)) u_alu (
    .a_i     (x_q),
    .b_i     (y_q),
    .sub_i   (is_sub),
    .res_o   (alu_res),
    .carry_o (alu_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (instr_valid) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_WRITE;
`ifdef ILLEGAL_TRAP_EN
      ST_WRITE:  state_d = is_illegal ? ST_HALT : ST_IDLE;
      ST_HALT:   state_d = ST_HALT;
`else
      ST_WRITE:  state_d = ST_IDLE;
`endif
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == ST_IDLE);
`ifdef ILLEGAL_TRAP_EN
    done        = (state_q == ST_WRITE) && !is_illegal;
`else
    done        = (state_q == ST_WRITE);
`endif
    dout_valid  = (state_q == ST_WRITE) && is_disp;
  end

  // The instruction is captured once; later input activity cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      opnd_q <= '0;
    end else if (accept) begin
      op_q   <= opcode;
      opnd_q <= operand;
    end
  end

  // dout changes on entry to WRITE so dout_valid/done see the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      res_c_q <= 1'b0;
      dout_q  <= '0;
    end else if (state_q == ST_EXEC) begin
      res_q   <= alu_res;
      res_c_q <= alu_c;
      if (is_disp)     dout_q <= z_q;
      else if (is_clr) dout_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      flag_c_q <= 1'b0;
    end else if (state_q == ST_WRITE) begin
      if (is_ldx) x_q <= opnd_q;
      if (is_ldy) y_q <= opnd_q;
      if (is_add || is_sub) begin
        z_q      <= res_q;
        flag_c_q <= res_c_q;
      end
      if (is_clr) begin
        x_q      <= '0;
        y_q      <= '0;
        z_q      <= '0;
        flag_c_q <= 1'b0;
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   illegal_q <= 1'b0;
    else if (state_q == ST_EXEC && is_illegal)    illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign dout   = dout_q;
  assign flag_c = flag_c_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit (4-bit data, 3-bit opcode).
module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] opcode;
  logic [3:0] operand;
  logic [3:0] dout;
  logic       dout_valid;
  logic       flag_c;
  logic       done;
  logic       illegal;

  int total;
  int bad;
  int done_cnt;
  int dv_cnt;

  control_unit #(.DATA_W(4), .OP_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .operand     (operand),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .flag_c      (flag_c),
    .done        (done),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1)       done_cnt++;
    if (dout_valid === 1'b1) dv_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  // Called at a negedge with the unit idle; returns at the negedge after WRITE.
  task automatic issue(input logic [2:0] op, input logic [3:0] val);
    int w;
    w = 0;
    while (instr_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (instr_ready !== 1'b1) begin
      $display("FAIL issue_ready got=%b want=1", instr_ready);
      bad++;
    end
    opcode = op; operand = val; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    opcode  = 3'($urandom);
    operand = 4'($urandom);
    @(negedge clk);
    total++;
    if (instr_ready !== 1'b0) begin
      $display("FAIL busy_ready got=%b want=0", instr_ready);
      bad++;
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin
      $display("FAIL write_done got=%b want=1 op=%0d", done, op);
      bad++;
    end
    total++;
    if (dout_valid !== (op == 3'd5)) begin
      $display("FAIL write_dout_valid got=%b want=%b op=%0d", dout_valid, (op == 3'd5), op);
      bad++;
    end
    $display("txn op=%0d operand=%0d dout=%0d flag_c=%b", op, val, dout, flag_c);
    @(negedge clk);
  endtask

  task automatic check_out(input string name, input logic [3:0] exp_dout, input logic exp_c);
    total++;
    if (dout !== exp_dout) begin
      $display("FAIL %s_dout got=%0d want=%0d", name, dout, exp_dout);
      bad++;
    end
    total++;
    if (flag_c !== exp_c) begin
      $display("FAIL %s_flag_c got=%b want=%b", name, flag_c, exp_c);
      bad++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({instr_ready, dout, flag_c, done, dout_valid, illegal} !== {1'b1, 4'd0, 4'b0000}) begin
      $display("FAIL reset_outputs got=%b want=%b",
               {instr_ready, dout, flag_c, done, dout_valid, illegal}, {1'b1, 4'd0, 4'b0000});
      bad++;
    end
    $display("txn reset ready=%b dout=%0d", instr_ready, dout);
  endtask

  task automatic test_add;
    int d0, v0;
    rst_n = 1'b1;  // first accept on the very next rising edge
    d0 = done_cnt; v0 = dv_cnt;
    issue(3'd0, 4'd2);
    issue(3'd1, 4'd1);
    issue(3'd2, 4'd0);
    issue(3'd5, 4'd0);
    check_out("add", 4'd3, 1'b0);
    total++;
    if (done_cnt - d0 != 4) begin
      $display("FAIL add_done_pulses got=%0d want=4", done_cnt - d0);
      bad++;
    end
    total++;
    if (dv_cnt - v0 != 1) begin
      $display("FAIL add_dv_pulses got=%0d want=1", dv_cnt - v0);
      bad++;
    end
  endtask

  task automatic test_sub;
    issue(3'd0, 4'd1);
    issue(3'd1, 4'd2);
    issue(3'd3, 4'd0);
    issue(3'd5, 4'd0);
    check_out("sub", 4'd15, 1'b1);
  endtask

  task automatic test_carry_clr;
    issue(3'd0, 4'd9);
    issue(3'd1, 4'd8);
    issue(3'd2, 4'd0);
    issue(3'd5, 4'd0);
    check_out("carry", 4'd1, 1'b1);
    issue(3'd4, 4'd0);
    check_out("clr", 4'd0, 1'b0);
    issue(3'd5, 4'd0);
    check_out("clr_disp", 4'd0, 1'b0);
  endtask

  task automatic test_back_to_back;
    int acc, low, v0;
    acc = 0; low = 0; v0 = dv_cnt;
    opcode = 3'd5; operand = 4'd0; instr_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (instr_ready === 1'b1) acc++;
      else                      low++;
      @(posedge clk);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    $display("txn back_to_back accepts=%0d ready_low=%0d", acc, low);
    total++;
    if (acc != 3) begin
      $display("FAIL b2b_accepts got=%0d want=3", acc);
      bad++;
    end
    total++;
    if (low != 9) begin
      $display("FAIL b2b_ready_low got=%0d want=9", low);
      bad++;
    end
    total++;
    if (dv_cnt - v0 != 3) begin
      $display("FAIL b2b_dv_pulses got=%0d want=3", dv_cnt - v0);
      bad++;
    end
  endtask

  task automatic test_reset_abort;
    int d0;
    issue(3'd0, 4'd5);
    issue(3'd1, 4'd5);
    d0 = done_cnt;
    opcode = 3'd2; operand = 4'd0; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);  // EXEC
    rst_n = 1'b0;
    #1;
    total++;
    if (instr_ready !== 1'b1 || done !== 1'b0) begin
      $display("FAIL abort_async got=ready%b/done%b want=ready1/done0", instr_ready, done);
      bad++;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (instr_ready !== 1'b1) begin
      $display("FAIL abort_ready got=%b want=1", instr_ready);
      bad++;
    end
    total++;
    if (done_cnt != d0) begin
      $display("FAIL abort_done got=%0d want=%0d", done_cnt, d0);
      bad++;
    end
    $display("txn reset_abort ready=%b", instr_ready);
    issue(3'd5, 4'd0);
    check_out("abort_z", 4'd0, 1'b0);
  endtask

  task automatic test_illegal;
    issue(3'd0, 4'd3);
    issue(3'd1, 4'd4);
    issue(3'd2, 4'd0);
    issue(3'd5, 4'd0);
    check_out("pre_ill", 4'd7, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    begin
      int d0;
      d0 = done_cnt;
      opcode = 3'd7; operand = 4'd15; instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (illegal !== 1'b1) begin
        $display("FAIL trap_illegal got=%b want=1", illegal);
        bad++;
      end
      repeat (6) @(negedge clk);
      total++;
      if (instr_ready !== 1'b0 || done_cnt != d0) begin
        $display("FAIL trap_halt got=ready%b/dones%0d want=ready0/dones%0d",
                 instr_ready, done_cnt - d0, 0);
        bad++;
      end
      $display("txn trap illegal=%b ready=%b", illegal, instr_ready);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (instr_ready !== 1'b1 || illegal !== 1'b0) begin
        $display("FAIL trap_reset got=ready%b/ill%b want=ready1/ill0", instr_ready, illegal);
        bad++;
      end
    end
`else
    begin
      int d0, v0;
      d0 = done_cnt; v0 = dv_cnt;
      issue(3'd7, 4'd15);
      total++;
      if (done_cnt - d0 != 1 || dv_cnt != v0) begin
        $display("FAIL nop_pulses got=done%0d/dv%0d want=done1/dv0", done_cnt - d0, dv_cnt - v0);
        bad++;
      end
      check_out("nop", 4'd7, 1'b0);
      total++;
      if (illegal !== 1'b0) begin
        $display("FAIL nop_illegal got=%b want=0", illegal);
        bad++;
      end
      issue(3'd3, 4'd0);  // X=3,Y=4 survive the NOP: 3-4 borrows
      issue(3'd5, 4'd0);
      check_out("nop_xy", 4'd15, 1'b1);
    end
`endif
  endtask

  initial begin
    total = 0; bad = 0; done_cnt = 0; dv_cnt = 0;
    rst_n = 1'b0; instr_valid = 1'b0; opcode = 3'd0; operand = 4'd0;
    test_reset;
    test_add;
    test_sub;
    test_carry_clr;
    test_back_to_back;
    test_reset_abort;
    test_illegal;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter DATA_W, default 4, operand/register width in bits.
REQ-002 Parameter OP_W, default 3, opcode width in bits.
REQ-003 Single clock; reset asynchronous, active-low.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 instr_valid  input  1  instruction source presents opcode/operand.
REQ-007 instr_ready  output  1  unit can accept an instruction.
REQ-008 opcode  input  OP_W  instruction opcode.
REQ-009 operand  input  DATA_W  immediate operand (the source's "in" value).
REQ-010 dout  output  DATA_W  display register.
REQ-011 dout_valid  output  1  one-cycle pulse when dout updates.
REQ-012 flag_c  output  1  carry/borrow of the last ADD/SUB.
REQ-013 done  output  1  one-cycle pulse when an instruction retires.
REQ-014 illegal  output  1  sticky illegal-opcode flag; constant 0 unless ILLEGAL_TRAP_EN is defined.

Function
REQ-015 The FSM states SHALL be IDLE, DECODE, EXEC, WRITE, plus HALT only when ILLEGAL_TRAP_EN is defined.
REQ-016 instr_ready SHALL be 1 exactly when the state is IDLE.
REQ-017 An instruction SHALL be accepted on the rising edge where instr_valid and instr_ready are both 1, with opcode and operand latched on that edge.
REQ-018 Transitions SHALL be IDLE->DECODE on accept, then DECODE->EXEC->WRITE->IDLE unconditionally, for a fixed 4-cycle issue interval.
REQ-019 instr_valid SHALL be ignored outside IDLE; opcode and operand changes outside IDLE SHALL NOT affect the instruction in flight.
REQ-020 Internal registers X, Y, Z (DATA_W each) SHALL update only on the edge leaving WRITE, with done=1 during WRITE.
REQ-021 Opcode 000 (LDX) SHALL load operand into X.
REQ-022 Opcode 001 (LDY) SHALL load operand into Y.
REQ-023 Opcode 010 (ADD) SHALL set Z to (X+Y) mod 2^DATA_W and flag_c to the carry-out.
REQ-024 Opcode 011 (SUB) SHALL set Z to (X-Y) mod 2^DATA_W and flag_c=1 when X<Y (borrow).
REQ-025 Opcode 100 (CLR) SHALL zero X, Y, Z, flag_c and dout.
REQ-026 Opcode 101 (DISP) SHALL copy Z into dout and pulse dout_valid for one cycle, coincident with done.
REQ-027 The ALU result SHALL be computed in EXEC and registered, so the WRITE-cycle value is independent of inputs.
REQ-028 Opcodes 110/111 without ILLEGAL_TRAP_EN SHALL retire as NOPs, with done pulsed and no state change.
REQ-029 Back-to-back: instr_valid held high SHALL yield accepts exactly every 4 cycles.

Reset
REQ-030 While rst_n=0: state=IDLE; X, Y, Z, dout and flag_c = 0; dout_valid, done and illegal = 0; instr_ready=1.
REQ-031 Reset assertion in any state SHALL abort the in-flight instruction immediately, with no partial register writes.
REQ-032 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-033 When ILLEGAL_TRAP_EN is defined, opcode 110/111 SHALL set illegal=1 in WRITE and then enter HALT.
REQ-034 In HALT, instr_ready=0 and done is never asserted; only reset exits HALT.
REQ-035 When ILLEGAL_TRAP_EN is not defined, HALT logic SHALL be absent and REQ-028 applies.

Structure
REQ-036 Package cpu_pkg SHALL hold the opcode enumeration (LDX..DISP), the FSM state typedef, and the DATA_W/OP_W defaults.
REQ-037 Sub-module alu SHALL implement combinational ADD/SUB producing a result and carry/borrow; all other logic stays in control_unit.

Verification
REQ-038 LDX 2, LDY 1, ADD, DISP -> dout=3, flag_c=0, one dout_valid pulse, four done pulses.
REQ-039 LDX 1, LDY 2, SUB, DISP -> dout=15, flag_c=1.
REQ-040 LDX 9, LDY 8, ADD, DISP -> dout=1, flag_c=1; CLR then DISP -> dout=0, flag_c=0.
REQ-041 instr_valid held high for 12 cycles -> exactly 3 accepts, instr_ready low for 3 of every 4 cycles.
REQ-042 rst_n pulsed low during EXEC of an ADD with X=5, Y=5 -> Z stays 0, no done, IDLE with instr_ready=1 after release.
REQ-043 Opcode 111 -> with ILLEGAL_TRAP_EN: illegal=1, instr_ready stuck 0 until reset; without it: one done pulse, X/Y/Z unchanged.
